// File: rtl/sys_bus_pkg.sv
// sys_bus_pkg: shared bus size encoding, arbiter states and byte-enable helper
package sys_bus_pkg;
   typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} bus_size_t;
   typedef enum logic [1:0] {ARB, LOCKED, FORCE} arb_state_t;
   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
      return size == SZ_BYTE ? 4'b0001 << addr_lo :
             size == SZ_HALF ? 4'b0011 << {addr_lo[1], 1'b0} : 4'b1111;
   endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; prio = 1 means m1 wins the next contention
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       set_m1,
   output logic [1:0] gnt
);
   logic prio;
   assign gnt = {req[1] & (~req[0] | prio), req[0] & (~req[1] | ~prio)};
   always_ff @(posedge clk)
      if (reset) prio <= 1'b0;
      else if (set_m1) prio <= 1'b1;
      else if (|gnt) prio <= gnt[0];
endmodule

// File: rtl/dbus_ram_arbiter.sv
// dbus_ram_arbiter: shares the RAM data port between CPU dBus (m0) and loader/debug bridge (m1)
module dbus_ram_arbiter
   import sys_bus_pkg::*;
#(
   parameter int WL          = 32,
   parameter int RAM_ADDR_WL = 13,
   parameter int MAX_LOCK    = 256
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   m0_cmd_valid,
   output logic                   m0_cmd_ready,
   input  logic                   m0_cmd_wr,
   input  logic [WL-1:0]          m0_cmd_addr,
   input  logic [WL-1:0]          m0_cmd_data,
   input  logic [1:0]             m0_cmd_size,
   output logic                   m0_rsp_valid,
   output logic [WL-1:0]          m0_rsp_data,
   output logic                   m0_rsp_error,
   input  logic                   m1_cmd_valid,
   output logic                   m1_cmd_ready,
   input  logic                   m1_cmd_wr,
   input  logic [WL-1:0]          m1_cmd_addr,
   input  logic [WL-1:0]          m1_cmd_data,
   input  logic [1:0]             m1_cmd_size,
   output logic                   m1_rsp_valid,
   output logic [WL-1:0]          m1_rsp_data,
   output logic                   m1_rsp_error,
   input  logic                   m1_lock,
   output logic [WL/8-1:0]        ram_we,
   output logic [RAM_ADDR_WL-1:0] ram_addr,
   output logic [WL-1:0]          ram_din,
   input  logic [WL-1:0]          ram_dout
);
   localparam int CW = $clog2(MAX_LOCK + 1);
   arb_state_t state;
   logic [CW-1:0] cnt;
   logic [1:0] req, gnt, size;
   logic [WL-1:0] addr;
   logic sel, wr, in_range, pend, own, err, rv;
   assign req = reset ? 2'b00 :
                state == LOCKED ? {m1_cmd_valid, 1'b0} :
                state == FORCE ? {1'b0, m0_cmd_valid} : {m1_cmd_valid, m0_cmd_valid};
   rr_arb2 u_rr (.clk(clk), .reset(reset), .req(req), .set_m1(state == FORCE), .gnt(gnt));
   assign m0_cmd_ready = gnt[0];
   assign m1_cmd_ready = gnt[1];
   assign sel = gnt[1];
   assign addr = sel ? m1_cmd_addr : m0_cmd_addr;
   assign size = sel ? m1_cmd_size : m0_cmd_size;
   assign wr = sel ? m1_cmd_wr : m0_cmd_wr;
   // addr[WL-1] selects IO space, so it counts as out of range here too
   assign in_range = addr[WL-1:RAM_ADDR_WL+2] == '0;
   assign ram_addr = addr[RAM_ADDR_WL+1:2];
   assign ram_din = sel ? m1_cmd_data : m0_cmd_data;
   assign ram_we = (|gnt && wr && in_range) ? byte_en(size, addr[1:0]) : '0;
   always_ff @(posedge clk)
      if (reset) begin
         pend <= 1'b0;
         own  <= 1'b0;
         err  <= 1'b0;
      end else begin
         pend <= |gnt & ~wr;
         own  <= sel;
         err  <= ~in_range;
      end
   assign rv = pend & ~reset;
   assign m0_rsp_valid = rv & ~own;
   assign m1_rsp_valid = rv & own;
   assign m0_rsp_error = rv & ~own & err;
   assign m1_rsp_error = rv & own & err;
   assign m0_rsp_data = (rv & ~own & ~err) ? ram_dout : '0;
   assign m1_rsp_data = (rv & own & ~err) ? ram_dout : '0;
   // cnt counts cycles m1 has owned the port, including the ARB grant that took the lock
   always_ff @(posedge clk)
      if (reset) begin
         state <= ARB;
         cnt   <= '0;
      end else if (state == ARB) begin
         if (gnt[1] && m1_lock) begin
            state <= (MAX_LOCK == 1) ? FORCE : LOCKED;
            cnt   <= CW'(1);
         end
      end else if (state == LOCKED) begin
         if (!m1_lock) begin
            state <= ARB;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
            if (cnt + 1'b1 == CW'(MAX_LOCK)) state <= FORCE;
         end
      end else begin
         state <= ARB;
         cnt   <= '0;
      end
endmodule

// File: tb/tb_dbus_ram_arbiter.sv
// tb_dbus_ram_arbiter: directed bench with RAM model and read-response scoreboard
module tb_dbus_ram_arbiter;
   logic clk = 1'b0, reset;
   logic m0_cmd_valid, m0_cmd_ready, m0_cmd_wr, m0_rsp_valid, m0_rsp_error;
   logic m1_cmd_valid, m1_cmd_ready, m1_cmd_wr, m1_rsp_valid, m1_rsp_error, m1_lock;
   logic [31:0] m0_cmd_addr, m0_cmd_data, m0_rsp_data, m1_cmd_addr, m1_cmd_data, m1_rsp_data;
   logic [1:0] m0_cmd_size, m1_cmd_size;
   logic [3:0] ram_we;
   logic [12:0] ram_addr;
   logic [31:0] ram_din, ram_dout, w;
   logic [31:0] mem [8192];
   bit written [8192];
   typedef struct packed {logic own; logic err; logic [31:0] data; logic [15:0] due;} exp_t;
   exp_t sb[$];
   exp_t e;
   int checks = 0, errors = 0, cyc = 0, k0 = 0, k1 = 0;
   logic [9:0] lock_pat = 10'b0111101111;
   always #5 clk = ~clk;
   dbus_ram_arbiter #(.MAX_LOCK(4)) dut (
      .clk(clk), .reset(reset),
      .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready), .m0_cmd_wr(m0_cmd_wr),
      .m0_cmd_addr(m0_cmd_addr), .m0_cmd_data(m0_cmd_data), .m0_cmd_size(m0_cmd_size),
      .m0_rsp_valid(m0_rsp_valid), .m0_rsp_data(m0_rsp_data), .m0_rsp_error(m0_rsp_error),
      .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready), .m1_cmd_wr(m1_cmd_wr),
      .m1_cmd_addr(m1_cmd_addr), .m1_cmd_data(m1_cmd_data), .m1_cmd_size(m1_cmd_size),
      .m1_rsp_valid(m1_rsp_valid), .m1_rsp_data(m1_rsp_data), .m1_rsp_error(m1_rsp_error),
      .m1_lock(m1_lock), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
      .ram_dout(ram_dout)
   );
   function automatic logic [31:0] init_word(input int a);
      return 32'hA500_0000 | a;
   endfunction
   // RAM model: unwritten words read back as init_word(word address)
   always @(posedge clk) begin
      ram_dout <= written[ram_addr] ? mem[ram_addr] : init_word(int'(ram_addr));
      if (|ram_we) begin
         w = written[ram_addr] ? mem[ram_addr] : init_word(int'(ram_addr));
         for (int b = 0; b < 4; b++) if (ram_we[b]) w[8*b+:8] = ram_din[8*b+:8];
         mem[ram_addr] <= w;
         written[ram_addr] <= 1'b1;
      end
   end
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic expect_rsp(input logic own, input logic err, input logic [31:0] data);
      sb.push_back('{own, err, data, 16'(cyc + 1)});
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input int m, input logic v, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] sz);
      if (m == 0) begin
         m0_cmd_valid = v; m0_cmd_wr = wr; m0_cmd_addr = a; m0_cmd_data = d; m0_cmd_size = sz;
      end else begin
         m1_cmd_valid = v; m1_cmd_wr = wr; m1_cmd_addr = a; m1_cmd_data = d; m1_cmd_size = sz;
      end
   endtask
   task automatic idle();
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd2);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd2);
   endtask
   // both masters present reads; g is the master expected to win this cycle
   task automatic arb_step(input logic lock, input logic g);
      drive(0, 1'b1, 1'b0, 32'h200 + 4 * k0, 32'h0, 2'd2);
      drive(1, 1'b1, 1'b0, 32'h400 + 4 * k1, 32'h0, 2'd2);
      m1_lock = lock;
      #3;
      chk("grant", 64'({m1_cmd_ready, m0_cmd_ready}), 64'(g ? 2'b10 : 2'b01));
      expect_rsp(g, 1'b0, init_word(g ? 32'h100 + k1 : 32'h80 + k0));
      if (g) k1++; else k0++;
      tick();
   endtask
   task automatic single(input int m, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] sz);
      idle();
      drive(m, 1'b1, wr, a, d, sz);
      #3;
      chk("ready", 64'({m1_cmd_ready, m0_cmd_ready}), 64'(m == 1 ? 2'b10 : 2'b01));
   endtask
   always @(negedge clk) if (m0_rsp_valid || m1_rsp_valid) begin
      if (sb.size() == 0) chk("rsp_unexpected", 64'({m0_rsp_valid, m1_rsp_valid}), 64'(0));
      else begin
         e = sb.pop_front();
         chk("rsp", {13'b0, m0_rsp_valid, m1_rsp_valid,
                     m1_rsp_valid ? m1_rsp_error : m0_rsp_error,
                     m1_rsp_valid ? m1_rsp_data : m0_rsp_data, 16'(cyc)},
                    {13'b0, ~e.own, e.own, e.err, e.data, e.due});
      end
   end
   initial begin
      reset = 1'b1;
      m1_lock = 1'b0;
      idle();
      drive(0, 1'b1, 1'b1, 32'h0, 32'h1, 2'd2);
      drive(1, 1'b1, 1'b0, 32'h4, 32'h0, 2'd2);
      tick();
      tick();
      #3;
      chk("reset_out", 64'({m0_cmd_ready, m1_cmd_ready, ram_we, m0_rsp_valid, m1_rsp_valid,
                            m0_rsp_error, m1_rsp_error}), 64'(0));
      chk("reset_data", 64'({m0_rsp_data, m1_rsp_data}), 64'(0));
      reset = 1'b0;
      idle();
      tick();
      single(0, 1'b0, 32'h10, 32'h0, 2'd2);
      chk("m0_rd_addr", 64'(ram_addr), 64'(4));
      chk("m0_rd_we", 64'(ram_we), 64'(0));
      expect_rsp(1'b0, 1'b0, init_word(4));
      tick();
      for (int i = 0; i < 8; i++) arb_step(1'b0, i % 2 == 0);
      single(1, 1'b1, 32'h103, 32'hDD00_0000, 2'd0);
      chk("wr_byte", 64'({ram_we, ram_addr, ram_din}), 64'({4'b1000, 13'h40, 32'hDD00_0000}));
      tick();
      single(1, 1'b1, 32'h2, 32'hBEEF_0000, 2'd1);
      chk("wr_half", 64'({ram_we, ram_addr}), 64'({4'b1100, 13'h0}));
      tick();
      single(0, 1'b1, 32'h8, 32'h1234_5678, 2'd2);
      chk("wr_word", 64'(ram_we), 64'(4'b1111));
      tick();
      single(0, 1'b0, 32'h100, 32'h0, 2'd2);
      expect_rsp(1'b0, 1'b0, 32'hDD00_0040);
      tick();
      single(1, 1'b0, 32'h0, 32'h0, 2'd2);
      expect_rsp(1'b1, 1'b0, 32'hBEEF_0000);
      tick();
      single(0, 1'b0, 32'h8, 32'h0, 2'd2);
      expect_rsp(1'b0, 1'b0, 32'h1234_5678);
      tick();
      single(0, 1'b0, 32'h0001_0000, 32'h0, 2'd2);
      expect_rsp(1'b0, 1'b1, 32'h0);
      tick();
      single(0, 1'b0, 32'h8000_0000, 32'h0, 2'd2);
      expect_rsp(1'b0, 1'b1, 32'h0);
      tick();
      single(0, 1'b0, 32'h0000_7FFC, 32'h0, 2'd2);
      expect_rsp(1'b0, 1'b0, init_word(32'h1FFF));
      tick();
      single(0, 1'b1, 32'h0001_0000, 32'hFFFF_FFFF, 2'd2);
      chk("oor_wr_we", 64'(ram_we), 64'(0));
      tick();
      for (int i = 0; i < 10; i++) arb_step(1'b1, lock_pat[i]);
      for (int i = 0; i < 4; i++) arb_step(1'b0, i % 2 == 0);
      single(1, 1'b0, 32'h30, 32'h0, 2'd2);
      tick();
      idle();
      reset = 1'b1;
      #3;
      chk("rst_mid_out", 64'({m0_cmd_ready, m1_cmd_ready, ram_we, m0_rsp_valid, m1_rsp_valid,
                              m0_rsp_error, m1_rsp_error}), 64'(0));
      chk("rst_mid_data", 64'({m0_rsp_data, m1_rsp_data}), 64'(0));
      tick();
      reset = 1'b0;
      #3;
      chk("rst_drop", 64'({m0_rsp_valid, m1_rsp_valid}), 64'(0));
      tick();
      arb_step(1'b0, 1'b0);
      idle();
      tick();
      tick();
      chk("sb_empty", 64'(sb.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
